// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, default widths, operand-use helpers
// and the ID/EX interlock FSM encoding.
package pipe_pkg;

    localparam int DEF_REG_INDEX_BIT_WIDTH = 4;
    localparam int DEF_BITWIDTH            = 32;

    localparam logic [3:0] OP_NOP    = 4'b0000;
    localparam logic [3:0] OP_LW     = 4'b0001;
    localparam logic [3:0] OP_BRANCH = 4'b0010;
    localparam logic [3:0] OP_SW     = 4'b0011;
    localparam logic [3:0] OP_ADD    = 4'b1100;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_BUBBLE   = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    function automatic logic uses_rt(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SW) || (op == OP_BRANCH);
    endfunction

    function automatic logic writes_rd(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_LW);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load now in EX.
module load_use_detect
    import pipe_pkg::*;
#(
    parameter int RW = DEF_REG_INDEX_BIT_WIDTH
) (
    input  logic          id_valid_i,
    input  logic [3:0]    id_opcode_i,
    input  logic [RW-1:0] id_rs_index_i,
    input  logic [RW-1:0] id_rt_index_i,
    input  logic          ex_valid_i,
    input  logic [3:0]    ex_opcode_i,
    input  logic [RW-1:0] ex_rd_index_i,
    output logic          lu_o
);

    logic rs_hit;
    logic rt_hit;

    always_comb begin
        rs_hit = (ex_rd_index_i == id_rs_index_i);
        rt_hit = uses_rt(id_opcode_i) && (ex_rd_index_i == id_rt_index_i);
        lu_o   = id_valid_i && ex_valid_i && (ex_opcode_i == OP_LW) && (rs_hit || rt_hit);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and
// a hold state that waits out a busy data memory.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int REG_INDEX_BIT_WIDTH = DEF_REG_INDEX_BIT_WIDTH,
    parameter int bitwidth            = DEF_BITWIDTH,
    parameter int CNT_WIDTH           = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           id_valid,
    input  logic [3:0]                     id_opcode,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] id_rs_index,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] id_rt_index,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] id_rd_index,
    input  logic [bitwidth-1:0]            id_rs_data,
    input  logic [bitwidth-1:0]            id_rt_data,
    input  logic                           mem_busy,
    input  logic                           branch_taken,
    output logic                           stall_if_id,
    output logic                           ex_valid,
    output logic [3:0]                     ex_opcode,
    output logic [REG_INDEX_BIT_WIDTH-1:0] ex_rs_index,
    output logic [REG_INDEX_BIT_WIDTH-1:0] ex_rt_index,
    output logic [REG_INDEX_BIT_WIDTH-1:0] ex_rd_index,
    output logic [bitwidth-1:0]            ex_rs_data,
    output logic [bitwidth-1:0]            ex_rt_data,
    output logic [CNT_WIDTH-1:0]           stall_count
);

    localparam int RW = REG_INDEX_BIT_WIDTH;

    logic [1:0]           state_q, state_d;
    logic                 pend_q, pend_d;
    logic                 valid_q, valid_d;
    logic [3:0]           op_q, op_d;
    logic [RW-1:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [bitwidth-1:0]  rsd_q, rsd_d, rtd_q, rtd_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 lu;
    logic                 flush_now;
    logic                 load_bubble;
    logic                 load_id;

    load_use_detect #(.RW(RW)) u_lu (
        .id_valid_i    (id_valid),
        .id_opcode_i   (id_opcode),
        .id_rs_index_i (id_rs_index),
        .id_rt_index_i (id_rt_index),
        .ex_valid_i    (valid_q),
        .ex_opcode_i   (op_q),
        .ex_rd_index_i (rd_q),
        .lu_o          (lu)
    );

    // pend_q can only be set while in MEM_WAIT, so it is harmless elsewhere
    assign flush_now   = branch_taken || pend_q;
    assign stall_if_id = !rst && (mem_busy || (state_q == ST_MEM_WAIT) || (lu && !flush_now));

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        load_bubble = 1'b0;
        load_id     = 1'b0;
        if (state_q == ST_MEM_WAIT) begin
            if (branch_taken) pend_d = 1'b1;
            if (!mem_busy) begin
                state_d = ST_RUN;
                pend_d  = 1'b0;
                if (flush_now) load_bubble = 1'b1;
                else           load_id     = 1'b1;
            end
        end else if (mem_busy) begin
            state_d = ST_MEM_WAIT;
            pend_d  = branch_taken;
        end else if (branch_taken) begin
            state_d     = ST_RUN;
            load_bubble = 1'b1;
        end else if (lu) begin
            state_d     = ST_BUBBLE;
            load_bubble = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end else begin
            state_d = ST_RUN;
            load_id = 1'b1;
        end
    end

    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        rsd_d   = rsd_q;
        rtd_d   = rtd_q;
        if (load_bubble) begin
            valid_d = 1'b0;
            op_d    = OP_NOP;
            rs_d    = '0;
            rt_d    = '0;
            rd_d    = '0;
            rsd_d   = '0;
            rtd_d   = '0;
        end else if (load_id) begin
            valid_d = id_valid;
            op_d    = id_opcode;
            rs_d    = id_rs_index;
            rt_d    = id_rt_index;
            rd_d    = id_rd_index;
            rsd_d   = id_rs_data;
            rtd_d   = id_rt_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            op_q    <= OP_NOP;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            rsd_q   <= '0;
            rtd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            op_q    <= op_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            rsd_q   <= rsd_d;
            rtd_q   <= rtd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_opcode   = op_q;
    assign ex_rs_index = rs_q;
    assign ex_rt_index = rt_q;
    assign ex_rd_index = rd_q;
    assign ex_rs_data  = rsd_q;
    assign ex_rt_data  = rtd_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; expected EX contents go through a queue.
module tb_id_ex_stage;

    localparam int RW = 4;
    localparam int BW = 32;
    localparam int CW = 8;

    localparam logic [3:0] NOP = 4'b0000;
    localparam logic [3:0] LW  = 4'b0001;
    localparam logic [3:0] SW  = 4'b0011;
    localparam logic [3:0] ADD = 4'b1100;

    typedef struct packed {
        logic          v;
        logic [3:0]    op;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic [BW-1:0] a;
        logic [BW-1:0] b;
    } ex_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [3:0]    id_opcode;
    logic [RW-1:0] id_rs_index, id_rt_index, id_rd_index;
    logic [BW-1:0] id_rs_data, id_rt_data;
    logic          mem_busy, branch_taken;
    logic          stall_if_id, ex_valid;
    logic [3:0]    ex_opcode;
    logic [RW-1:0] ex_rs_index, ex_rt_index, ex_rd_index;
    logic [BW-1:0] ex_rs_data, ex_rt_data;
    logic [CW-1:0] stall_count;
    ex_t           obs;
    ex_t           sb[$];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.REG_INDEX_BIT_WIDTH(RW), .bitwidth(BW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_opcode    (id_opcode),
        .id_rs_index  (id_rs_index),
        .id_rt_index  (id_rt_index),
        .id_rd_index  (id_rd_index),
        .id_rs_data   (id_rs_data),
        .id_rt_data   (id_rt_data),
        .mem_busy     (mem_busy),
        .branch_taken (branch_taken),
        .stall_if_id  (stall_if_id),
        .ex_valid     (ex_valid),
        .ex_opcode    (ex_opcode),
        .ex_rs_index  (ex_rs_index),
        .ex_rt_index  (ex_rt_index),
        .ex_rd_index  (ex_rd_index),
        .ex_rs_data   (ex_rs_data),
        .ex_rt_data   (ex_rt_data),
        .stall_count  (stall_count)
    );

    assign obs = {ex_valid, ex_opcode, ex_rs_index, ex_rt_index, ex_rd_index, ex_rs_data, ex_rt_data};

    function automatic ex_t mk(input logic v, input logic [3:0] op, input int rs, input int rt,
                               input int rd, input int a, input int b);
        ex_t e;
        e.v  = v;
        e.op = op;
        e.rs = RW'(rs);
        e.rt = RW'(rt);
        e.rd = RW'(rd);
        e.a  = BW'(a);
        e.b  = BW'(b);
        return e;
    endfunction

    task automatic set_id(input ex_t e);
        id_valid    = e.v;
        id_opcode   = e.op;
        id_rs_index = e.rs;
        id_rt_index = e.rt;
        id_rd_index = e.rd;
        id_rs_data  = e.a;
        id_rt_data  = e.b;
    endtask

    // One clock: check the combinational freeze, then the EX register after the edge.
    task automatic cyc(input string tag, input logic exp_stall, input ex_t exp_ex);
        ex_t e;
        #1;
        checks++;
        assert (stall_if_id === exp_stall) else begin
            errors++;
            $error("FAIL %s stall_if_id: got %b expected %b", tag, stall_if_id, exp_stall);
        end
        sb.push_back(exp_ex);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s ex: got %h expected %h", tag, obs, e);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [CW-1:0] exp);
        checks++;
        assert (stall_count === exp) else begin
            errors++;
            $error("FAIL %s stall_count: got %h expected %h", tag, stall_count, exp);
        end
    endtask

    initial begin
        ex_t bub, h;
        bub = '0;
        rst = 1'b1;
        mem_busy = 1'b1;
        branch_taken = 1'b0;
        set_id(mk(1, ADD, 3, 4, 1, 5, 7));
        cyc("reset0", 1'b0, bub);
        cyc("reset1", 1'b0, bub);
        chk_cnt("reset", '0);

        rst = 1'b0;
        mem_busy = 1'b0;
        cyc("add", 1'b0, mk(1, ADD, 3, 4, 1, 5, 7));
        set_id(mk(1, LW, 1, 0, 2, 9, 0));
        cyc("lw", 1'b0, mk(1, LW, 1, 0, 2, 9, 0));
        set_id(mk(1, ADD, 2, 6, 3, 11, 12));
        cyc("lu_rs", 1'b1, bub);
        chk_cnt("lu_rs", 8'd1);
        cyc("after_bubble", 1'b0, mk(1, ADD, 2, 6, 3, 11, 12));
        chk_cnt("after_bubble", 8'd1);

        set_id(mk(1, LW, 1, 0, 2, 9, 0));
        cyc("lw2", 1'b0, mk(1, LW, 1, 0, 2, 9, 0));
        set_id(mk(1, SW, 8, 2, 0, 3, 4));
        cyc("lu_rt", 1'b1, bub);
        cyc("sw", 1'b0, mk(1, SW, 8, 2, 0, 3, 4));
        chk_cnt("lu_rt", 8'd2);

        set_id(mk(1, LW, 1, 0, 2, 9, 0));
        cyc("lw3", 1'b0, mk(1, LW, 1, 0, 2, 9, 0));
        h = mk(1, LW, 5, 2, 7, 13, 14);
        set_id(h);
        cyc("no_rt_use", 1'b0, h);
        chk_cnt("no_rt_use", 8'd2);

        set_id(mk(1, ADD, 1, 1, 4, 1, 2));
        mem_busy = 1'b1;
        cyc("mem_hold1", 1'b1, h);
        branch_taken = 1'b1;
        cyc("mem_hold2", 1'b1, h);
        branch_taken = 1'b0;
        cyc("mem_hold3", 1'b1, h);
        mem_busy = 1'b0;
        cyc("mem_exit_flush", 1'b1, bub);
        cyc("post_mem", 1'b0, mk(1, ADD, 1, 1, 4, 1, 2));

        set_id(mk(1, LW, 1, 0, 2, 9, 0));
        cyc("lw4", 1'b0, mk(1, LW, 1, 0, 2, 9, 0));
        set_id(mk(1, ADD, 2, 2, 5, 6, 6));
        branch_taken = 1'b1;
        cyc("flush_over_lu", 1'b0, bub);
        branch_taken = 1'b0;
        chk_cnt("flush_over_lu", 8'd2);
        cyc("after_flush", 1'b0, mk(1, ADD, 2, 2, 5, 6, 6));

        set_id(mk(1, ADD, 3, 3, 6, 1, 1));
        mem_busy = 1'b1;
        branch_taken = 1'b1;
        cyc("mem_and_br", 1'b1, mk(1, ADD, 2, 2, 5, 6, 6));
        mem_busy = 1'b0;
        branch_taken = 1'b0;
        cyc("mem_and_br_exit", 1'b1, bub);
        cyc("after_mem_br", 1'b0, mk(1, ADD, 3, 3, 6, 1, 1));

        mem_busy = 1'b1;
        branch_taken = 1'b1;
        cyc("pre_rst_hold", 1'b1, mk(1, ADD, 3, 3, 6, 1, 1));
        rst = 1'b1;
        branch_taken = 1'b0;
        cyc("rst_in_wait", 1'b0, bub);
        chk_cnt("rst_in_wait", '0);
        rst = 1'b0;
        mem_busy = 1'b0;
        set_id(mk(1, ADD, 4, 5, 9, 21, 22));
        cyc("post_rst_run", 1'b0, mk(1, ADD, 4, 5, 9, 21, 22));

        // back-to-back hazards: the same LW re-enters ID behind itself
        set_id(mk(1, LW, 2, 0, 2, 1, 0));
        cyc("sat_lw", 1'b0, mk(1, LW, 2, 0, 2, 1, 0));
        for (int i = 0; i < 300; i++) begin
            cyc("sat_lu", 1'b1, bub);
            cyc("sat_cap", 1'b0, mk(1, LW, 2, 0, 2, 1, 0));
            if (i == 99) chk_cnt("sat_mid", 8'd100);
        end
        chk_cnt("sat_end", 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with a load-use interlock and a memory-wait hold FSM. It sits directly upstream of `forwardingUnit`: its registered `ex_rs_*` / `ex_rt_*` outputs are the `reg_index` / `reg_data` operands that the forwarding unit resolves against MEM and WB. It also generates the IF/ID freeze, inserts bubbles, and honours branch flushes.

## Interface
Parameters:
- `REG_INDEX_BIT_WIDTH`, 4: register index width (16 registers; index 0 is an ordinary register).
- `bitwidth`, 32: datapath width.
- `CNT_WIDTH`, 16: width of the stall performance counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_opcode`  in  4  ID opcode.
- `id_rs_index`, `id_rt_index`, `id_rd_index`  in  REG_INDEX_BIT_WIDTH  ID register fields.
- `id_rs_data`, `id_rt_data`  in  bitwidth  register-file read data.
- `mem_busy`  in  1  data memory not ready; whole pipe holds.
- `branch_taken`  in  1  EX resolved a taken branch; flush ID.
- `stall_if_id`  out  1  combinational; freeze PC and IF/ID this cycle.
- `ex_valid`  out  1  EX holds a real instruction.
- `ex_opcode`  out  4  EX opcode.
- `ex_rs_index`, `ex_rt_index`, `ex_rd_index`  out  REG_INDEX_BIT_WIDTH.
- `ex_rs_data`, `ex_rt_data`  out  bitwidth.
- `stall_count`  out  CNT_WIDTH  saturating count of load-use bubbles.

## Operation
- Opcodes: NOP 4'b0000, LW 4'b0001, BRANCH 4'b0010, SW 4'b0011, ADD 4'b1100.
- Load-use hazard (`lu`) fires when all of the following hold: `id_valid`, `ex_valid`, `ex_opcode`==LW, and either `ex_rd_index`==`id_rs_index` or (`uses_rt(id_opcode)` and `ex_rd_index`==`id_rt_index`). `uses_rt` is true for ADD, SW and BRANCH.
- Bubble: the EX register loads `ex_valid`=0, `ex_opcode`=NOP, and all index and data fields 0.
- FSM states: RUN, BUBBLE, MEM_WAIT.
  - RUN, `mem_busy`=1: go to MEM_WAIT. Hold the EX register. Set `pending_flush` if `branch_taken`.
  - RUN, `branch_taken`=1: load a bubble and stay in RUN. `stall_if_id`=0.
  - RUN, `lu`=1: load a bubble, go to BUBBLE, increment `stall_count`. `stall_if_id`=1.
  - RUN, otherwise: capture the ID fields into EX.
  - BUBBLE: same priority as RUN. `lu` cannot fire because `ex_valid`=0. With no hold and no flush, capture ID and return to RUN.
  - MEM_WAIT: hold the EX register. `stall_if_id`=1. `branch_taken` sets `pending_flush`. When `mem_busy` drops, go to RUN. In that transition cycle, load a bubble if `pending_flush` or `branch_taken`; otherwise capture ID. Clear `pending_flush` on the transition.
- Priority: `rst` > `mem_busy` > flush (`branch_taken` or `pending_flush`) > `lu`.
- `stall_if_id` = `mem_busy` | (state==MEM_WAIT) | (`lu` & no flush this cycle).
- `stall_count` saturates at all-ones and never wraps.

## Timing
- All `ex_*` outputs and `stall_count` are registered and update on the clock edge. Latency from ID to EX is one cycle.
- `stall_if_id` is combinational from state and inputs, valid in the same cycle.
- Reset values: state RUN, `pending_flush` 0, `ex_valid` 0, `ex_opcode` NOP, all indices and data 0, `stall_count` 0. `stall_if_id` is 0 during reset.
- A reset asserted in MEM_WAIT or BUBBLE discards the held instruction and any pending flush.
- A load-use stall costs exactly one bubble. The dependent instruction reaches EX two cycles after the LW entered EX, where `forwardingUnit` supplies it from WB.
- `mem_busy` and `branch_taken` asserted in the same cycle: MEM_WAIT wins, and the flush is applied on exit.

## Structure
- Shared package `pipe_pkg` holds:
  - the opcode constants;
  - `REG_INDEX_BIT_WIDTH` and `bitwidth` defaults;
  - the `uses_rt(opcode)` and `writes_rd(opcode)` functions;
  - the FSM state encoding.
- One combinational sub-module, `load_use_detect`, computes `lu` from the EX and ID fields. The FSM and the EX register stay in `id_ex_stage`.

## Test plan
- Straight-line ADD, ID rs=3/rt=4, data 5/7, `mem_busy`=0 -> next cycle `ex_valid`=1, `ex_opcode`=1100, `ex_rs_data`=5, `ex_rt_data`=7; `stall_if_id` stays 0.
- LW rd=2 in EX, ADD rs=2 in ID -> `stall_if_id`=1 for one cycle, then a bubble in EX (`ex_valid`=0), then ADD in EX; `stall_count`=1.
- LW rd=2 in EX, ID has an opcode that does not use rt with rt=2 and rs=5 -> no stall; `stall_count` stays 0.
- `mem_busy` high for 3 cycles with `branch_taken` pulsed in the 2nd -> EX held for 3 cycles, `stall_if_id`=1 throughout, then a bubble on exit.
- 65537 back-to-back load-use hazards -> `stall_count` ends at 16'hFFFF.
- `rst` asserted in MEM_WAIT -> next cycle all outputs at their reset values, state RUN, `stall_if_id`=0.
